// File: rtl/quad_input_filter.sv
// Quadrature input conditioner for one rotary encoder: a two-flop synchronizer
// per channel followed by a per-channel stability filter, plus diagnostics
// for rejected glitches and for simultaneous A/B output changes.
//
// Ports:
//   CLOCK_50    in   system clock, 50 MHz
//   reset       in   synchronous, active-high reset
//   a_in, b_in  in   raw encoder channels, asynchronous, idle high
//   a_out       out  filtered channel A, to decoder
//   b_out       out  filtered channel B, to decoder
//   glitch_cnt  out  saturating count of rejected transitions, both channels
//   dbl_err     out  one-cycle pulse: a_out and b_out updated on the same edge
module quad_input_filter #(
  parameter int unsigned STABLE_CYCLES = 500,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                a_in,
  input  logic                b_in,
  output logic                a_out,
  output logic                b_out,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                dbl_err
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SUM_W = GLITCH_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Channel index 0 is A, index 1 is B.
  logic [1:0]            raw;
  logic [1:0]            sync_s1;
  logic [1:0]            sync_s2;
  logic [1:0]            filt_q;
  logic [1:0]            filt_nxt;
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_nxt;
  logic [1:0]            glitch_evt;
  logic [SUM_W-1:0]      glitch_sum;
  logic [GLITCH_W-1:0]   glitch_nxt;
  logic                  dbl_nxt;

  assign raw = {b_in, a_in};

  // Two-flop synchronizer; flops reset to the idle-high level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_s1 <= 2'b11;
      sync_s2 <= 2'b11;
    end else begin
      sync_s1 <= raw;
      sync_s2 <= sync_s1;
    end
  end

  // Stability filter: follow sync_s2 only after it has differed from the
  // output for STABLE_CYCLES consecutive clocks; an early return is a glitch.
  always_comb begin
    filt_nxt   = filt_q;
    cnt_nxt    = cnt_q;
    glitch_evt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync_s2[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_nxt[i] = sync_s2[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (cnt_q[i] != '0) begin
        cnt_nxt[i]    = '0;
        glitch_evt[i] = 1'b1;
      end
    end
  end

  // Glitch counter adds 0..2 per cycle; the extra sum bit flags overflow so
  // a +2 step from max-1 clamps instead of wrapping.
  always_comb begin
    glitch_sum = {1'b0, glitch_cnt} + SUM_W'(glitch_evt[0]) + SUM_W'(glitch_evt[1]);
    glitch_nxt = glitch_sum[GLITCH_W] ? {GLITCH_W{1'b1}} : glitch_sum[GLITCH_W-1:0];
  end

  // Both filtered outputs flipping together is an illegal quadrature step.
  always_comb begin
    dbl_nxt = &(filt_nxt ^ filt_q);
  end

  // Filter state and diagnostic registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_q     <= 2'b11;
      cnt_q      <= '0;
      glitch_cnt <= '0;
      dbl_err    <= 1'b0;
    end else begin
      filt_q     <= filt_nxt;
      cnt_q      <= cnt_nxt;
      glitch_cnt <= glitch_nxt;
      dbl_err    <= dbl_nxt;
    end
  end

  assign a_out = filt_q[0];
  assign b_out = filt_q[1];

endmodule
